// File: rtl/rvfi_serial_pkg.sv
// Shared types and helpers for the RVFI channel serializer.
// Record packing, MSB first: {rs1_addr, rs1_rdata, rs2_addr, rs2_rdata, rd_addr, rd_wdata}.
package rvfi_serial_pkg;

    localparam int unsigned ADDR_W   = 5;
    localparam int unsigned ORDER_W  = 64;
    localparam int unsigned MAX_CH   = 32;
    localparam int unsigned XLEN_DEF = 32;

    function automatic int unsigned rec_w(input int unsigned xlen);
        return 3 * ADDR_W + 3 * xlen;
    endfunction

    // Field offsets for the default register width.
    localparam int unsigned REC_W_DEF      = 3 * ADDR_W + 3 * XLEN_DEF;
    localparam int unsigned RD_WDATA_LSB   = 0;
    localparam int unsigned RD_ADDR_LSB    = XLEN_DEF;
    localparam int unsigned RS2_RDATA_LSB  = XLEN_DEF + ADDR_W;
    localparam int unsigned RS2_ADDR_LSB   = 2 * XLEN_DEF + ADDR_W;
    localparam int unsigned RS1_RDATA_LSB  = 2 * XLEN_DEF + 2 * ADDR_W;
    localparam int unsigned RS1_ADDR_LSB   = 3 * XLEN_DEF + 2 * ADDR_W;

    typedef struct packed {
        logic [ADDR_W-1:0]   rs1_addr;
        logic [XLEN_DEF-1:0] rs1_rdata;
        logic [ADDR_W-1:0]   rs2_addr;
        logic [XLEN_DEF-1:0] rs2_rdata;
        logic [ADDR_W-1:0]   rd_addr;
        logic [XLEN_DEF-1:0] rd_wdata;
    } rec_t;

    function automatic int unsigned popcount(input logic [MAX_CH-1:0] v);
        int unsigned n;
        n = 0;
        for (int unsigned i = 0; i < MAX_CH; i++) begin
            n += int'(v[i]);
        end
        return n;
    endfunction

    // Channel index of the slot-th set bit of v, counting from bit 0.
    function automatic int unsigned compact_idx(input logic [MAX_CH-1:0] v,
                                                input int unsigned slot);
        int unsigned seen;
        int unsigned idx;
        logic        found;
        seen  = 0;
        idx   = 0;
        found = 1'b0;
        for (int unsigned i = 0; i < MAX_CH; i++) begin
            if (v[i] && !found) begin
                if (seen == slot) begin
                    idx   = i;
                    found = 1'b1;
                end
                seen++;
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/rvfi_serial_fifo.sv
// Multi-write / single-read record store with wrapping pointers and an occupancy level.
// Writes up to NRET pre-compacted entries per cycle; clear drops all content.
module rvfi_serial_fifo
    import rvfi_serial_pkg::*;
#(
    parameter int unsigned NRET  = 2,
    parameter int unsigned W     = 175,
    parameter int unsigned DEPTH = 8
) (
    input  logic                       clock,
    input  logic                       resetn,
    input  logic                       clear,
    input  logic                       push,
    input  logic [$clog2(NRET+1)-1:0]  push_cnt,
    input  logic [NRET*W-1:0]          push_data,
    input  logic                       pop,
    output logic [W-1:0]               head,
    output logic [$clog2(DEPTH):0]     level
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned LW = PW + 1;

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wr_ptr_q, rd_ptr_q;
    logic [LW-1:0] level_q, level_d;

    always_comb begin
        level_d = level_q;
        if (push) level_d = level_d + LW'(push_cnt);
        if (pop)  level_d = level_d - LW'(1);
    end

    // Memory is reset too so nothing stale is visible after reset.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < int'(DEPTH); i++) mem[i] <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else if (clear) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (push) begin
                for (int j = 0; j < int'(NRET); j++) begin
                    if (j < int'(push_cnt)) mem[wr_ptr_q + PW'(j)] <= push_data[j*W +: W];
                end
                wr_ptr_q <= wr_ptr_q + PW'(push_cnt);
            end
            if (pop) rd_ptr_q <= rd_ptr_q + PW'(1);
            level_q <= level_d;
        end
    end

    assign head  = mem[rd_ptr_q];
    assign level = level_q;

endmodule

// File: rtl/rvfi_channel_serializer.sv
// Serializes NRET RVFI retire channels onto one valid/ready record stream.
// Define RVFI_SERIAL_ORDER_CHECK_EN to enable the sticky rvfi_order continuity check.
module rvfi_channel_serializer
    import rvfi_serial_pkg::*;
#(
    parameter int unsigned NRET  = 2,
    parameter int unsigned XLEN  = 32,
    parameter int unsigned DEPTH = 8
) (
    input  logic                          clock,
    input  logic                          resetn,
    input  logic                          flush,
    input  logic [NRET-1:0]               in_valid,
    input  logic [NRET*ORDER_W-1:0]       in_order,
    input  logic [NRET*rec_w(XLEN)-1:0]   in_rec,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [ORDER_W-1:0]            out_order,
    output logic [rec_w(XLEN)-1:0]        out_rec,
    output logic [$clog2(DEPTH):0]        level,
    output logic                          overflow,
    output logic                          order_err
);

    localparam int unsigned REC_W = rec_w(XLEN);
    localparam int unsigned ENT_W = ORDER_W + REC_W;
    localparam int unsigned KW    = $clog2(NRET + 1);
    localparam int unsigned LW    = $clog2(DEPTH) + 1;

    logic [MAX_CH-1:0]      valid_ext;
    logic [KW-1:0]          k;
    logic                   room, push, pop;
    logic [NRET*ENT_W-1:0]  packed_data;
    logic [ENT_W-1:0]       head;
    logic                   overflow_q;

    assign valid_ext = MAX_CH'(in_valid);
    assign k         = KW'(popcount(valid_ext));

    // Space is judged on the pre-pop level; a same-cycle pop frees nothing.
    assign room = ({1'b0, level} + (LW+1)'(k)) <= (LW+1)'(DEPTH);
    assign push = !flush && (k != '0) && room;
    assign pop  = !flush && out_valid && out_ready;

    always_comb begin
        int unsigned idx;
        packed_data = '0;
        for (int j = 0; j < int'(NRET); j++) begin
            idx = compact_idx(valid_ext, unsigned'(j));
            packed_data[j*ENT_W +: ENT_W] = {in_order[idx*ORDER_W +: ORDER_W],
                                             in_rec[idx*REC_W +: REC_W]};
        end
    end

    rvfi_serial_fifo #(
        .NRET  (NRET),
        .W     (ENT_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clock     (clock),
        .resetn    (resetn),
        .clear     (flush),
        .push      (push),
        .push_cnt  (k),
        .push_data (packed_data),
        .pop       (pop),
        .head      (head),
        .level     (level)
    );

    assign out_valid = (level != '0);
    assign out_order = head[ENT_W-1 -: ORDER_W];
    assign out_rec   = head[REC_W-1:0];

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            overflow_q <= 1'b0;
        end else if (!flush && (k != '0) && !room) begin
            overflow_q <= 1'b1;
        end
    end

    assign overflow = overflow_q;

`ifdef RVFI_SERIAL_ORDER_CHECK_EN
    logic [ORDER_W-1:0] last_order_q;
    logic               have_last_q;
    logic               order_err_q;

    // Flush restarts the baseline but keeps any error already flagged.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            last_order_q <= '0;
            have_last_q  <= 1'b0;
            order_err_q  <= 1'b0;
        end else if (flush) begin
            last_order_q <= '0;
            have_last_q  <= 1'b0;
        end else if (pop) begin
            if (have_last_q && (out_order != last_order_q + ORDER_W'(1))) order_err_q <= 1'b1;
            last_order_q <= out_order;
            have_last_q  <= 1'b1;
        end
    end

    assign order_err = order_err_q;
`else
    assign order_err = 1'b0;
`endif

endmodule

// File: tb/tb_rvfi_channel_serializer.sv
// Randomized and directed bench for rvfi_channel_serializer against a queue-based model.
module tb_rvfi_channel_serializer;
    import rvfi_serial_pkg::*;

    localparam int unsigned NRET  = 2;
    localparam int unsigned XLEN  = 32;
    localparam int unsigned DEPTH = 8;
    localparam int unsigned RW    = 15 + 3 * XLEN;
    localparam int unsigned LW    = $clog2(DEPTH) + 1;

    typedef struct packed {
        logic [63:0]   order;
        logic [RW-1:0] rec;
    } ent_t;

    logic                 clock = 1'b0;
    logic                 resetn = 1'b0;
    logic                 flush = 1'b0;
    logic [NRET-1:0]      in_valid = '0;
    logic [NRET*64-1:0]   in_order = '0;
    logic [NRET*RW-1:0]   in_rec = '0;
    logic                 out_valid;
    logic                 out_ready = 1'b0;
    logic [63:0]          out_order;
    logic [RW-1:0]        out_rec;
    logic [LW-1:0]        level;
    logic                 overflow;
    logic                 order_err;

    ent_t        q[$];
    logic        m_ovf, m_err, m_have;
    logic [63:0] m_last;
    int          n_checks = 0;
    int          n_fail = 0;

    rvfi_channel_serializer #(
        .NRET  (NRET),
        .XLEN  (XLEN),
        .DEPTH (DEPTH)
    ) dut (
        .clock     (clock),
        .resetn    (resetn),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_order  (in_order),
        .in_rec    (in_rec),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_order (out_order),
        .out_rec   (out_rec),
        .level     (level),
        .overflow  (overflow),
        .order_err (order_err)
    );

    always #5 clock = ~clock;

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [RW-1:0] rand_rec();
        return RW'({$urandom, $urandom, $urandom, $urandom});
    endfunction

    task automatic check_all(input string tag);
        logic exp_err;
`ifdef RVFI_SERIAL_ORDER_CHECK_EN
        exp_err = m_err;
`else
        exp_err = 1'b0;
`endif
        check_eq({tag, ".level"}, 128'(level), 128'(q.size()));
        check_eq({tag, ".out_valid"}, 128'(out_valid), 128'(q.size() != 0));
        check_eq({tag, ".overflow"}, 128'(overflow), 128'(m_ovf));
        check_eq({tag, ".order_err"}, 128'(order_err), 128'(exp_err));
        if (q.size() != 0) begin
            check_eq({tag, ".out_order"}, 128'(out_order), 128'(q[0].order));
            check_eq({tag, ".out_rec"}, 128'(out_rec), 128'(q[0].rec));
        end
    endtask

    // One clock: drive on the falling edge, update the model, check after the rising edge.
    task automatic cycle(input logic [NRET-1:0] v, input logic [63:0] o0, input logic [63:0] o1,
                         input logic rdy, input logic fl, input string tag);
        int k;
        bit fits;
        @(negedge clock);
        in_valid  = v;
        in_order  = {o1, o0};
        in_rec    = {rand_rec(), rand_rec()};
        out_ready = rdy;
        flush     = fl;
        if (fl) begin
            q.delete();
            m_have = 1'b0;
            m_last = '0;
        end else begin
            k    = $countones(v);
            fits = (k <= int'(DEPTH) - q.size());
            if (rdy && q.size() != 0) begin
                if (m_have && q[0].order != m_last + 64'd1) m_err = 1'b1;
                m_last = q[0].order;
                m_have = 1'b1;
                void'(q.pop_front());
            end
            if (k != 0) begin
                if (fits) begin
                    for (int c = 0; c < int'(NRET); c++) begin
                        if (v[c]) q.push_back('{order: in_order[c*64 +: 64], rec: in_rec[c*RW +: RW]});
                    end
                end else begin
                    m_ovf = 1'b1;
                end
            end
        end
        @(posedge clock);
        #1;
        check_all(tag);
    endtask

    task automatic do_reset(input string tag);
        @(negedge clock);
        #2;
        resetn    = 1'b0;
        in_valid  = '0;
        flush     = 1'b0;
        out_ready = 1'b0;
        q.delete();
        m_ovf  = 1'b0;
        m_err  = 1'b0;
        m_have = 1'b0;
        m_last = '0;
        #1;
        check_all(tag);
        check_eq({tag, ".out_order_zero"}, 128'(out_order), 128'(0));
        check_eq({tag, ".out_rec_zero"}, 128'(out_rec), 128'(0));
        @(negedge clock);
        resetn = 1'b1;
    endtask

    initial begin
        logic [NRET-1:0] v;
        logic [63:0]     nxt;
        rec_t            ch1;

        do_reset("reset");

        // Full batch of two, drained back to back.
        cycle(2'b11, 64'd10, 64'd11, 1'b1, 1'b0, "pair");
        check_eq("pair.first_order", 128'(out_order), 128'(10));
        for (int i = 0; i < 3; i++) cycle(2'b00, 0, 0, 1'b1, 1'b0, "pair_drain");

        // Sparse valid keeps only channel 1.
        cycle(2'b10, 64'd99, 64'd5, 1'b1, 1'b0, "sparse");
        ch1 = rec_t'(in_rec[RW +: RW]);
        check_eq("sparse.rd_wdata", 128'(out_rec[RD_WDATA_LSB +: XLEN]), 128'(ch1.rd_wdata));
        check_eq("sparse.rs1_addr", 128'(out_rec[RS1_ADDR_LSB +: ADDR_W]), 128'(ch1.rs1_addr));
        for (int i = 0; i < 2; i++) cycle(2'b00, 0, 0, 1'b1, 1'b0, "sparse_drain");

        // Fill to DEPTH, then one more record overflows.
        do_reset("reset_fill");
        for (int i = 0; i < 4; i++) cycle(2'b11, 64'(2*i), 64'(2*i+1), 1'b0, 1'b0, "fill");
        check_eq("fill.no_overflow", 128'(overflow), 128'(0));
        cycle(2'b01, 64'd8, 64'd0, 1'b0, 1'b0, "full_push");
        check_eq("full.level", 128'(level), 128'(DEPTH));
        for (int i = 0; i < 9; i++) cycle(2'b00, 0, 0, 1'b1, 1'b0, "full_drain");

        // Level 7 with a two-record batch and a concurrent pop.
        do_reset("reset_l7");
        for (int i = 0; i < 3; i++) cycle(2'b11, 64'(2*i), 64'(2*i+1), 1'b0, 1'b0, "l7_fill");
        cycle(2'b01, 64'd6, 64'd0, 1'b0, 1'b0, "l7_fill");
        cycle(2'b11, 64'd7, 64'd8, 1'b1, 1'b0, "l7_reject");
        check_eq("l7.level6", 128'(level), 128'(6));

        // Wrap-around with steady single push/pop, then flush with a same-cycle push.
        do_reset("reset_wrap");
        for (int i = 0; i < 20; i++) cycle(2'b01, 64'(200+i), 64'd0, 1'b1, 1'b0, "wrap");
        cycle(2'b11, 64'd300, 64'd301, 1'b1, 1'b1, "wrap_flush");
        cycle(2'b00, 0, 0, 1'b1, 1'b0, "after_flush");

        // Order gap 3,4,6 then a fresh baseline after flush.
        do_reset("reset_order");
        cycle(2'b11, 64'd3, 64'd4, 1'b0, 1'b0, "ord_push");
        cycle(2'b01, 64'd6, 64'd0, 1'b0, 1'b0, "ord_push");
        for (int i = 0; i < 6; i++) cycle(2'b00, 0, 0, 1'b1, 1'b0, "ord_drain");
        cycle(2'b00, 0, 0, 1'b1, 1'b1, "ord_flush");
        cycle(2'b01, 64'd100, 64'd0, 1'b1, 1'b0, "ord_100");
        for (int i = 0; i < 2; i++) cycle(2'b00, 0, 0, 1'b1, 1'b0, "ord_100_drain");

        // Mid-operation reset loses content.
        do_reset("reset_mid_pre");
        for (int i = 0; i < 3; i++) cycle(2'b11, 64'(2*i), 64'(2*i+1), 1'b0, 1'b0, "mid_fill");
        do_reset("reset_mid");
        for (int i = 0; i < 2; i++) cycle(2'b00, 0, 0, 1'b1, 1'b0, "post_reset");

        // Random traffic with mostly contiguous orders.
        do_reset("reset_rand");
        nxt = 64'd1000;
        for (int i = 0; i < 400; i++) begin
            logic [63:0] o0, o1;
            v  = NRET'($urandom);
            o0 = nxt;
            if (v[0]) nxt++;
            o1 = nxt;
            if (v[1]) nxt++;
            if ($urandom_range(0, 31) == 0) nxt += 64'd2;
            cycle(v, o0, o1, 1'($urandom_range(0, 1)), $urandom_range(0, 40) == 0, "rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
